// File: rtl/sobel_pkg.sv
// Shared types for the Sobel 3x3 window stream: window layout and FSM states.
// No logic, so no latency and no backpressure of its own.
package sobel_pkg;
    localparam int SOBEL_PIX_W = 8;

    // Packed [row][col]: row 0 is the oldest (top) row, col 0 the leftmost column.
    typedef logic [2:0][2:0][SOBEL_PIX_W-1:0] window_t;

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;
endpackage

// File: rtl/sobel_line_buffer.sv
// One stored image row; single address, combinational read, write on enable.
// Read data is the old word at i_addr, so read-before-write falls out naturally.
module sobel_line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdat,
    output logic [WIDTH-1:0] o_rdat
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_rdat = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[i_addr] <= i_wdat;
        end
    end
endmodule

// File: rtl/sobel_window_stream.sv
// Raster pixel stream in, one 3x3 window per interior pixel out; window appears the cycle after its pixel.
// Single output register: in_ready = !out_valid || out_ready, held low while the last window drains.
module sobel_window_stream
    import sobel_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               in_valid,
    input  logic [PIX_W-1:0]   in_pixel,
    output logic               in_ready,
    input  logic               abort,
    output logic               out_valid,
    output logic [9*PIX_W-1:0] out_window,
    output logic               out_last,
    input  logic               out_ready,
    output logic               frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef logic [2:0][2:0][PIX_W-1:0] win_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    win_t             r_win, w_win_nxt;
    logic             r_out_vld, r_out_last, r_frame_done;
    logic             w_accept, w_col_last, w_frame_end, w_emit;
    logic [PIX_W-1:0] w_lb0_rd, w_lb1_rd;

    assign in_ready    = (r_state != DRAIN) && (!r_out_vld || out_ready);
    assign w_accept    = in_valid && in_ready && !abort;
    assign w_col_last  = (r_col == COL_LAST);
    assign w_frame_end = w_col_last && (r_row == ROW_LAST);
    // The col >= 2 gate keeps windows from straddling a row wrap.
    assign w_emit      = (r_row >= RW'(2)) && (r_col >= CW'(2));

    assign out_valid  = r_out_vld;
    assign out_window = r_win;
    assign out_last   = r_out_last;
    assign frame_done = r_frame_done;

    sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk    (clk),
        .i_en   (w_accept),
        .i_addr (r_col),
        .i_wdat (in_pixel),
        .o_rdat (w_lb1_rd)
    );

    sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk    (clk),
        .i_en   (w_accept),
        .i_addr (r_col),
        .i_wdat (w_lb1_rd),
        .o_rdat (w_lb0_rd)
    );

    always_comb begin
        w_win_nxt = r_win;
        for (int r = 0; r < 3; r++) begin
            w_win_nxt[r][0] = r_win[r][1];
            w_win_nxt[r][1] = r_win[r][2];
        end
        w_win_nxt[0][2] = w_lb0_rd;
        w_win_nxt[1][2] = w_lb1_rd;
        w_win_nxt[2][2] = in_pixel;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_accept) w_state_nxt = FILL;
                FILL:    if (w_accept && w_col_last && (r_row == RW'(1))) w_state_nxt = STREAM;
                STREAM:  if (w_accept && w_frame_end) w_state_nxt = DRAIN;
                DRAIN:   if (out_ready) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_win        <= '0;
            r_out_vld    <= 1'b0;
            r_out_last   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= (r_state == DRAIN) && out_ready && !abort;
            if (abort) begin
                r_col      <= '0;
                r_row      <= '0;
                r_out_vld  <= 1'b0;
                r_out_last <= 1'b0;
            end else if (w_accept) begin
                r_win      <= w_win_nxt;
                r_out_vld  <= w_emit;
                r_out_last <= w_emit && w_frame_end;
                r_col      <= w_col_last ? '0 : r_col + CW'(1);
                if (w_col_last) begin
                    r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
                end
            end else if (out_ready) begin
                r_out_vld  <= 1'b0;
                r_out_last <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sobel_window_stream.sv
// Bench for sobel_window_stream: 8x4 frames against an image-array model, plus a 3x3 instance.
module tb_sobel_window_stream;
    localparam int W = 8;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        in_valid = 1'b0, abort = 1'b0, out_ready = 1'b0;
    logic [7:0]  in_pixel = '0;
    logic        in_ready, out_valid, out_last, frame_done;
    logic [71:0] out_window;

    logic        c_in_valid = 1'b0, c_out_ready = 1'b0;
    logic [7:0]  c_in_pixel = '0;
    logic        c_in_ready, c_out_valid, c_out_last, c_frame_done;
    logic [71:0] c_out_window;

    always #5 clk = ~clk;

    sobel_window_stream #(.PIX_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_pixel(in_pixel),
        .in_ready(in_ready), .abort(abort), .out_valid(out_valid),
        .out_window(out_window), .out_last(out_last), .out_ready(out_ready),
        .frame_done(frame_done)
    );

    sobel_window_stream #(.PIX_W(8), .IMG_W(3), .IMG_H(3)) dut3 (
        .clk(clk), .n_rst(n_rst), .in_valid(c_in_valid), .in_pixel(c_in_pixel),
        .in_ready(c_in_ready), .abort(1'b0), .out_valid(c_out_valid),
        .out_window(c_out_window), .out_last(c_out_last), .out_ready(c_out_ready),
        .frame_done(c_frame_done)
    );

    typedef struct {
        logic [71:0] w;
        logic        last;
    } exp_t;

    typedef struct {
        int base;
        bit rnd;
        int nfr;
        int rdy_mode;
        int vld_mode;
        int exp_wins;
        int exp_done;
        int exp_first_tl;
        int exp_last_tl;
    } scen_t;

    logic [7:0] pix_q[$];
    exp_t       exp_q[$];
    int tests = 0, fails = 0;
    int done_cnt = 0, exp_done = 0;
    int win_seen, first_tl, last_tl;

    always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic load_frame(input int base, input bit rnd, input int npix, input bit drop_last);
        logic [7:0] img [H][W];
        exp_t e;
        int r, c;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = rnd ? 8'($urandom) : 8'(base + 8 * y + x);
        for (int k = 0; k < npix; k++) begin
            r = k / W;
            c = k % W;
            pix_q.push_back(img[r][c]);
            if (r >= 2 && c >= 2 && !(drop_last && k == npix - 1)) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e.w[(i * 3 + j) * 8 +: 8] = img[r - 2 + i][c - 2 + j];
                e.last = (r == H - 1 && c == W - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run(input int rdy_mode, input int vld_mode, input int budget);
        int   cyc = 0;
        bit   stall_pend = 0;
        logic [71:0] stall_win = '0;
        logic stall_last = 1'b0;
        exp_t e;
        while ((pix_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
            @(negedge clk);
            if (stall_pend) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_window", out_window, stall_win);
                chk("stall_last", out_last, stall_last);
            end
            in_valid = (pix_q.size() > 0) && (vld_mode == 0 || $urandom_range(0, 3) != 0);
            in_pixel = (pix_q.size() > 0) ? pix_q[0] : 8'h00;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = cyc[0];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (exp_q.size() == 0) out_ready = 1'b0;
            #1;
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                chk("window", out_window, e.w);
                chk("last", out_last, e.last);
                if (win_seen == 0) first_tl = int'(out_window[7:0]);
                last_tl = int'(out_window[7:0]);
                win_seen++;
            end
            stall_pend = out_valid && !out_ready;
            stall_win  = out_window;
            stall_last = out_last;
            if (in_valid && in_ready) void'(pix_q.pop_front());
            cyc++;
        end
        if (cyc >= budget) begin
            chk("run_timeout", 72'(cyc), 72'(budget - 1));
            pix_q.delete();
            exp_q.delete();
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    scen_t tbl[5];
    int    d0;
    logic [71:0] w3;

    initial begin
        tbl[0] = '{0,  0, 1, 0, 0, 12, 1, 0,  13};
        tbl[1] = '{0,  0, 1, 1, 0, 12, 1, 0,  13};
        tbl[2] = '{0,  0, 2, 0, 0, 24, 2, 0,  113};
        tbl[3] = '{20, 0, 1, 2, 2, 12, 1, 20, 33};
        tbl[4] = '{0,  1, 3, 2, 2, 36, 3, -1, -1};

        #12;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_window", out_window, 72'h0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        idle(2);

        for (int s = 0; s < 5; s++) begin
            win_seen = 0;
            first_tl = -1;
            last_tl  = -1;
            d0 = done_cnt;
            for (int f = 0; f < tbl[s].nfr; f++)
                load_frame(tbl[s].base + 100 * f, tbl[s].rnd, W * H, 0);
            run(tbl[s].rdy_mode, tbl[s].vld_mode, 3000);
            idle(3);
            chk("scen_windows", 72'(win_seen), 72'(tbl[s].exp_wins));
            chk("scen_frame_done", 72'(done_cnt - d0), 72'(tbl[s].exp_done));
            if (tbl[s].exp_first_tl >= 0) begin
                chk("scen_first_tl", 72'(first_tl), 72'(tbl[s].exp_first_tl));
                chk("scen_last_tl", 72'(last_tl), 72'(tbl[s].exp_last_tl));
            end
            chk("scen_idle_valid", out_valid, 1'b0);
        end
        exp_done = done_cnt;

        // Abort while a window is pending; the simultaneous junk pixel must be discarded.
        load_frame(0, 0, 21, 1);
        run(0, 0, 500);
        #1;
        chk("abort_pre_valid", out_valid, 1'b1);
        abort = 1'b1; in_valid = 1'b1; in_pixel = 8'hEE; out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_in_ready", in_ready, 1'b1);
        load_frame(50, 0, W * H, 0);
        run(2, 2, 1000);
        idle(3);
        exp_done += 1;
        chk("abort_frame_done", 72'(done_cnt), 72'(exp_done));

        // Reset in the middle of STREAM with a window pending.
        load_frame(0, 0, 28, 1);
        run(0, 0, 500);
        #1;
        chk("mrst_pre_valid", out_valid, 1'b1);
        n_rst = 1'b0;
        #1;
        chk("mrst_out_valid", out_valid, 1'b0);
        chk("mrst_in_ready", in_ready, 1'b1);
        chk("mrst_out_window", out_window, 72'h0);
        @(negedge clk);
        n_rst = 1'b1;
        load_frame(9, 0, W * H, 0);
        run(1, 0, 1000);
        idle(3);
        exp_done += 1;
        chk("mrst_frame_done", 72'(done_cnt), 72'(exp_done));

        // 3x3 frame: exactly one window, flagged last, then frame_done.
        for (int i = 0; i < 9; i++) w3[i * 8 +: 8] = 8'(i * 7 + 3);
        @(negedge clk);
        c_out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            c_in_valid = 1'b1;
            c_in_pixel = 8'(k * 7 + 3);
            @(negedge clk);
            if (k < 8) chk("s3_no_early_window", c_out_valid, 1'b0);
        end
        c_in_valid = 1'b0;
        chk("s3_valid", c_out_valid, 1'b1);
        chk("s3_last", c_out_last, 1'b1);
        chk("s3_window", c_out_window, w3);
        chk("s3_drain_in_ready", c_in_ready, 1'b0);
        @(negedge clk);
        chk("s3_frame_done", c_frame_done, 1'b1);
        chk("s3_valid_after", c_out_valid, 1'b0);
        @(negedge clk);
        chk("s3_frame_done_pulse", c_frame_done, 1'b0);
        chk("s3_in_ready_idle", c_in_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
